// File: rtl/blend_s_f.sv
// blend_s_f: weighted smooth/fine pixel blend, round + saturate.
// Three-stage valid/ready pipeline with bubble collapsing.
module blend_s_f #(
    parameter int PIXEL_BIT_WIDTH = 12,
    parameter int SAT_CNT_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 w_s,
    input  logic [7:0]                 w_f,
    input  logic [PIXEL_BIT_WIDTH-1:0] pix_s,
    input  logic [PIXEL_BIT_WIDTH-1:0] pix_f,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PIXEL_BIT_WIDTH-1:0] pix_out,
    output logic                       sat_out,
    output logic [SAT_CNT_WIDTH-1:0]   sat_cnt
);

    localparam int PW    = PIXEL_BIT_WIDTH;
    localparam int PRODW = PW + 8;
    localparam int SUMW  = PW + 9;

    localparam logic [SUMW-1:0] RND     = SUMW'(127);
    localparam logic [SUMW-1:0] DIV     = SUMW'(255);
    localparam logic [SUMW-1:0] PIX_MAX = {{9{1'b0}}, {PW{1'b1}}};

    logic              v1_q, v1_d;
    logic [PRODW-1:0]  ps_q, ps_d;
    logic [PRODW-1:0]  pf_q, pf_d;
    logic              v2_q, v2_d;
    logic [SUMW-1:0]   sum_q, sum_d;
    logic              v3_q, v3_d;
    logic [PW-1:0]     pix_q, pix_d;
    logic              sat_q, sat_d;
    logic [SAT_CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic              adv1, adv2, adv3;
    logic [SUMW-1:0]   quot;

    // Stage advance: a stage may load when empty or when its successor moves on.
    always_comb begin
        adv3 = !v3_q || out_ready;
        adv2 = !v2_q || adv3;
        adv1 = !v1_q || adv2;
    end

    // Next-state for the datapath, valid bits and saturation counter.
    always_comb begin
        v1_d  = v1_q;
        ps_d  = ps_q;
        pf_d  = pf_q;
        v2_d  = v2_q;
        sum_d = sum_q;
        v3_d  = v3_q;
        pix_d = pix_q;
        sat_d = sat_q;
        cnt_d = cnt_q;
        quot  = '0;

        if (adv1) begin
            v1_d = in_valid;
            if (in_valid) begin
                ps_d = PRODW'(w_s) * PRODW'(pix_s);
                pf_d = PRODW'(w_f) * PRODW'(pix_f);
            end
        end

        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                sum_d = SUMW'(ps_q) + SUMW'(pf_q) + RND;
            end
        end

        if (adv3) begin
            v3_d = v2_q;
            if (v2_q) begin
                quot = sum_q / DIV;
                if (quot > PIX_MAX) begin
                    pix_d = '1;
                    sat_d = 1'b1;
                end else begin
                    pix_d = quot[PW-1:0];
                    sat_d = 1'b0;
                end
            end
        end

        if (v3_q && out_ready && sat_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + SAT_CNT_WIDTH'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            ps_q  <= '0;
            pf_q  <= '0;
            v2_q  <= 1'b0;
            sum_q <= '0;
            v3_q  <= 1'b0;
            pix_q <= '0;
            sat_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            v1_q  <= v1_d;
            ps_q  <= ps_d;
            pf_q  <= pf_d;
            v2_q  <= v2_d;
            sum_q <= sum_d;
            v3_q  <= v3_d;
            pix_q <= pix_d;
            sat_q <= sat_d;
            cnt_q <= cnt_d;
        end
    end

    assign in_ready  = adv1;
    assign out_valid = v3_q;
    assign pix_out   = pix_q;
    assign sat_out   = sat_q;
    assign sat_cnt   = cnt_q;

endmodule

// File: tb/tb_blend_s_f.sv
// tb_blend_s_f: directed and random checks of blend_s_f
// against a queue-based reference model.
module tb_blend_s_f;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  w_s = '0;
    logic [7:0]  w_f = '0;
    logic [11:0] pix_s = '0;
    logic [11:0] pix_f = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] pix_out;
    logic        sat_out;
    logic [15:0] sat_cnt;

    blend_s_f #(.PIXEL_BIT_WIDTH(12), .SAT_CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .w_s(w_s), .w_f(w_f), .pix_s(pix_s), .pix_f(pix_f),
        .out_valid(out_valid), .out_ready(out_ready),
        .pix_out(pix_out), .sat_out(sat_out), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pix;
        int sat;
        int acc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mcnt = 0;
    int popped = 0;
    int sent = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Unclamped blend quotient straight from the arithmetic definition.
    function automatic int ref_q(input int ws, input int wf, input int ps, input int pf);
        return (ws * ps + wf * pf + 127) / 255;
    endfunction

    function automatic exp_t ref_beat(input int ws, input int wf, input int ps, input int pf);
        exp_t e;
        int r;
        r = ref_q(ws, wf, ps, pf);
        e.pix = (r > 4095) ? 4095 : r;
        e.sat = (r > 4095) ? 1 : 0;
        e.acc = 0;
        return e;
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    // Compare process: sampled mid-cycle, describes the upcoming edge.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mcnt = 0;
        end else begin
            exp_t e;
            bit exp_ov;
            chk("sat_cnt", int'(sat_cnt), mcnt);
            chk("in_ready", int'(in_ready), int'((q.size() < 3) || out_ready));
            exp_ov = (q.size() > 0) && (cyc >= q[0].acc + 2);
            chk("out_valid", int'(out_valid), int'(exp_ov));
            if (out_valid && q.size() > 0) begin
                chk("pix_out", int'(pix_out), q[0].pix);
                chk("sat_out", int'(sat_out), q[0].sat);
                if (out_ready) begin
                    if (q[0].sat == 1 && mcnt < 65535) mcnt++;
                    void'(q.pop_front());
                    popped++;
                end
            end
            if (in_valid && in_ready) begin
                e = ref_beat(int'(w_s), int'(w_f), int'(pix_s), int'(pix_f));
                e.acc = cyc + 1;
                q.push_back(e);
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_beat(input int ws, input int wf, input int ps, input int pf);
        w_s   = 8'(ws);
        w_f   = 8'(wf);
        pix_s = 12'(ps);
        pix_f = 12'(pf);
    endtask

    task automatic send(input int ws, input int wf, input int ps, input int pf);
        bit got;
        got = 1'b0;
        set_beat(ws, wf, ps, pf);
        in_valid = 1'b1;
        for (int k = 0; k < 500 && !got; k++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (got) sent++;
        else chk("send_timeout", 0, 1);
    endtask

    // One beat into an empty pipeline; checks latency and literal result.
    task automatic directed(input string name, input int ws, input int wf,
                            input int ps, input int pf,
                            input int exp_pix, input int exp_sat);
        int edges;
        out_ready = 1'b1;
        set_beat(ws, wf, ps, pf);
        in_valid = 1'b1;
        chk({name, "_in_ready"}, int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk({name, "_latency"}, edges, 3);
        chk({name, "_pix"}, int'(pix_out), exp_pix);
        chk({name, "_sat"}, int'(sat_out), exp_sat);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid = 1'b0;
        for (int k = 0; k < 100 && q.size() > 0; k++) tick(1);
        tick(2);
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        int s0;
        int p0;
        int rcyc;
        bit acc;

        tick(3);
        rst = 1'b0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_pix_out", int'(pix_out), 0);
        chk("rst_sat_out", int'(sat_out), 0);
        chk("rst_sat_cnt", int'(sat_cnt), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        chk("model_a", ref_q(255, 0, 1000, 3000), 1000);
        chk("model_b", ref_q(128, 127, 4095, 0), 2056);
        chk("model_c", ref_q(255, 255, 4095, 4095), 8190);
        chk("model_d", ref_q(0, 0, 4095, 4095), 0);

        directed("d_a", 255, 0, 1000, 3000, 1000, 0);
        tick(1);
        directed("d_b", 128, 127, 4095, 0, 2056, 0);
        tick(1);
        chk("d_pre_sat_cnt", int'(sat_cnt), 0);
        directed("d_sat", 255, 255, 4095, 4095, 4095, 1);
        tick(1);
        chk("d_sat_cnt", int'(sat_cnt), 1);
        directed("d_zero", 0, 0, 4095, 4095, 0, 0);
        tick(1);
        chk("d_zero_sat_cnt", int'(sat_cnt), 1);

        // out_ready held toggling while idle must change nothing.
        for (int i = 0; i < 4; i++) begin
            out_ready = ~out_ready;
            tick(1);
            chk("idle_out_valid", int'(out_valid), 0);
        end
        out_ready = 1'b1;

        // Back-pressure stream.
        s0 = sent;
        p0 = popped;
        fork
            begin
                for (int i = 0; i < 10; i++) send(255, 0, 100 + i * 7, 0);
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    out_ready = !(c >= 2 && c <= 8);
                    if (c == 6) begin
                        chk("bp_in_ready_low", int'(in_ready), 0);
                        chk("bp_accepted", sent - s0, 3);
                    end
                    tick(1);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_outputs", popped - p0, 10);

        // Random traffic.
        s0 = sent;
        p0 = popped;
        rcyc = 0;
        while ((sent - s0) < 10000 && rcyc < 60000) begin
            if (!in_valid && $urandom_range(0, 9) < 7) begin
                set_beat($urandom_range(0, 255), $urandom_range(0, 255),
                         $urandom_range(0, 4095), $urandom_range(0, 4095));
                in_valid = 1'b1;
            end
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            rcyc++;
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        chk("rand_sent", sent - s0, 10000);
        drain();
        chk("rand_outputs", popped - p0, 10000);
        chk("rand_sat_cnt", int'(sat_cnt), mcnt);

        // Reset with three beats in flight.
        out_ready = 1'b0;
        send(255, 255, 4095, 4095);
        send(255, 0, 11, 0);
        send(255, 0, 22, 0);
        chk("pre_rst_full", int'(in_ready), 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_sat_cnt", int'(sat_cnt), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        directed("post_rst", 255, 0, 333, 0, 333, 0);
        tick(1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
